rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the single RegisterFile write port between two sources:
  - the pipeline WB stage, which has priority and no backpressure;
  - a multi-cycle mul/div unit, which uses a valid/ready handshake.
- Buffers mul/div results in a small FIFO and publishes a pending-destination mask to the hazard unit.
- Breaks starvation of buffered results with a one-cycle forced pipeline stall.
- Its outputs drive RegWrite/Write_register/Write_data of the register file directly.

Parameters:
- FIFO_DEPTH, 2, mul/div result buffer entries; power of two, >=2.
- STARVE_LIMIT, 4, consecutive un-granted cycles with a non-empty FIFO before a forced grant; >=1.
- STAT_W, 16, width of the optional stall counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wb_RegWrite  in  1  WB stage write request.
- wb_Write_register  in  5  WB destination.
- wb_Write_data  in  32  WB data.
- md_valid  in  1  mul/div result valid.
- md_ready  out  1  FIFO can accept.
- md_Write_register  in  5  mul/div destination.
- md_Write_data  in  32  mul/div result.
- RegWrite  out  1  to register file.
- Write_register  out  5  to register file.
- Write_data  out  32  to register file.
- pipe_stall  out  1  forces WB to hold and re-present next cycle.
- pending_mask  out  32  bit r = 1 while a live FIFO entry targets register r.
- stall_count  out  STAT_W  forced-stall events (optional feature).

Behaviour:
- Reset (reset=0, async): FIFO empty, starve counter 0, FSM=IDLE. RegWrite=0, Write_register=0, Write_data=0, pipe_stall=0, stall_count=0. pending_mask=0 and md_ready=0 while reset is low.
- Push: when md_valid&&md_ready, capture {reg,data,live=1} at the tail. md_ready = !full (from registered count). md_valid held with md_ready=0 pushes nothing.
- Grant, evaluated each cycle; results registered, so writes reach the RF one cycle after the request:
  - pipe_stall=1: grant the FIFO head and ignore the WB input. The pipeline re-presents the WB request.
  - else wb_RegWrite && wb_Write_register!=0: grant WB.
  - else FIFO non-empty: pop the head. Issue the write only if the entry is live and reg!=0; otherwise drop the entry with RegWrite=0.
  - else RegWrite=0.
- Register 0: WB writes to reg 0 are treated as no request (slot free). md pushes to reg 0 are accepted and dropped at pop. pending_mask[0]=0 always.
- Squash: a granted WB write to r clears live on every FIFO entry already holding r. An entry pushed in the same cycle is NOT squashed.
- pending_mask: combinational OR over valid, live entries.
- FSM:
  - IDLE: FIFO empty.
  - WAIT: FIFO non-empty.
  - FORCE: pipe_stall=1 for exactly one cycle.
  - IDLE->WAIT on push.
  - WAIT->IDLE when the last entry pops.
  - In WAIT, the starve counter increments each cycle the head is not popped and clears on pop. At count==STARVE_LIMIT go to FORCE.
  - FORCE always pops the head and clears the counter, then goes to WAIT if the FIFO is still non-empty, else IDLE.
- Simultaneous push+pop: allowed when not full. Count is unchanged and pointers wrap mod FIFO_DEPTH.
- Reset asserted mid-operation: buffered entries are discarded. No partial write is emitted.

Optional Feature:
- RF_ARB_STATS_EN defined: stall_count increments on each entry to FORCE and saturates at all-ones.
- Not defined: stall_count is tied to 0 and no counter flops exist.

Test Plan:
- Reset release, then idle: all outputs 0, md_ready=1, pending_mask=0.
- md push {r8, 0x00000042} with WB idle -> cycle+1 pop; cycle+2 RegWrite=1, Write_register=8, Write_data=0x42. pending_mask[8]=1 from push until pop.
- WB writes r9 every cycle while md pushes {r10, 0x5} (STARVE_LIMIT=4):
  - after 4 un-granted cycles, pipe_stall=1 for one cycle and RF receives r10=0x5;
  - the next cycle RF receives the re-presented WB r9 write;
  - stall_count=1 with the macro defined.
- md pushes {r3, 0xAAAA}, then WB writes r3=0x1234 before the pop -> entry squashed; r3 finally holds 0x1234 and pending_mask[3] clears.
- Fill the FIFO (2 pushes with WB busy) -> md_ready=0; a third md_valid is held, then accepted one cycle after the first pop.
- Pushes to reg 0 and WB writes to reg 0 -> RegWrite never asserted for reg 0; FIFO still drains.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between the WB stage
// (priority, no backpressure) and a mul/div unit (valid/ready). Mul/div
// results wait in a small FIFO; a WB write to the same register squashes any
// older buffered result. A head entry that goes unserved for STARVE_LIMIT
// cycles causes a one-cycle pipe_stall during which the head is written.
// Optional: define RF_ARB_STATS_EN to count forced-stall events on stall_count.
module rf_write_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned STAT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_RegWrite,
  input  logic [4:0]        wb_Write_register,
  input  logic [31:0]       wb_Write_data,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [4:0]        md_Write_register,
  input  logic [31:0]       md_Write_data,
  output logic              RegWrite,
  output logic [4:0]        Write_register,
  output logic [31:0]       Write_data,
  output logic              pipe_stall,
  output logic [31:0]       pending_mask,
  output logic [STAT_W-1:0] stall_count
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FORCE} state_e;

  state_e                 state_q, state_d;
  logic [STV_W-1:0]       starve_q, starve_d;
  logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [FIFO_DEPTH-1:0]  valid_q, valid_d, live_q, live_d;
  logic [4:0]             ent_reg_q  [FIFO_DEPTH];
  logic [31:0]            ent_data_q [FIFO_DEPTH];
  logic                   regwrite_q, regwrite_d;
  logic [4:0]             wreg_q, wreg_d;
  logic [31:0]            wdata_q, wdata_d;

  logic        full, empty, push, pop, wb_req, wb_grant, forcing;
  logic [4:0]  head_reg;
  logic        head_live;
  logic [31:0] mask;

  // Grant decision, FIFO bookkeeping and squash of older buffered results.
  always_comb begin
    full      = (count_q == CNT_W'(FIFO_DEPTH));
    empty     = (count_q == '0);
    md_ready  = reset && !full;
    push      = md_valid && md_ready;
    forcing   = (state_q == S_FORCE);
    wb_req    = wb_RegWrite && (wb_Write_register != 5'd0);
    wb_grant  = !forcing && wb_req;
    pop       = !empty && (forcing || !wb_req);
    head_reg  = ent_reg_q[head_q];
    head_live = live_q[head_q];

    regwrite_d = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    if (wb_grant) begin
      regwrite_d = 1'b1;
      wreg_d     = wb_Write_register;
      wdata_d    = wb_Write_data;
    end else if (pop && head_live && (head_reg != 5'd0)) begin
      regwrite_d = 1'b1;
      wreg_d     = head_reg;
      wdata_d    = ent_data_q[head_q];
    end

    valid_d = valid_q;
    live_d  = live_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (wb_grant) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        if (valid_q[PTR_W'(i)] && (ent_reg_q[PTR_W'(i)] == wb_Write_register))
          live_d[PTR_W'(i)] = 1'b0;
      end
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      live_d[head_q]  = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    // Applied after the squash so an entry pushed this cycle stays live.
    if (push) begin
      valid_d[tail_q] = 1'b1;
      live_d[tail_q]  = 1'b1;
      tail_d          = tail_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Next-state logic for the starvation FSM.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      S_IDLE: begin
        starve_d = '0;
        if (push) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (pop) begin
          starve_d = '0;
          if (count_d == '0) state_d = S_IDLE;
        end else begin
          starve_d = starve_q + STV_W'(1);
          if (starve_d == STV_W'(STARVE_LIMIT)) state_d = S_FORCE;
        end
      end
      S_FORCE: begin
        starve_d = '0;
        state_d  = (count_d != '0) ? S_WAIT : S_IDLE;
      end
      default: begin
        starve_d = '0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // Destinations still owed a write by a live buffered result.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (valid_q[PTR_W'(i)] && live_q[PTR_W'(i)])
        mask[ent_reg_q[PTR_W'(i)]] = 1'b1;
    end
    mask[0]      = 1'b0;
    pending_mask = reset ? mask : '0;
  end

  // Control state and registered register-file write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      starve_q   <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      live_q     <= '0;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      live_q     <= live_d;
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
    end
  end

  // FIFO payload storage; validity is tracked separately so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_reg_q[tail_q]  <= md_Write_register;
      ent_data_q[tail_q] <= md_Write_data;
    end
  end

  assign RegWrite       = regwrite_q;
  assign Write_register = wreg_q;
  assign Write_data     = wdata_q;
  assign pipe_stall     = (state_q == S_FORCE);

`ifdef RF_ARB_STATS_EN
  logic [STAT_W-1:0] stat_q, stat_d;

  // Saturating count of entries into the forced-stall state.
  always_comb begin
    stat_d = stat_q;
    if ((state_q != S_FORCE) && (state_d == S_FORCE) && (stat_q != '1))
      stat_d = stat_q + STAT_W'(1);
  end

  // Stall statistic register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stat_q <= '0;
    else        stat_q <= stat_d;
  end

  assign stall_count = stat_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with default parameters
// (FIFO_DEPTH=2, STARVE_LIMIT=4).
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_RegWrite;
  logic [4:0]  wb_Write_register;
  logic [31:0] wb_Write_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_Write_register;
  logic [31:0] md_Write_data;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;
  logic        pipe_stall;
  logic [31:0] pending_mask;
  logic [15:0] stall_count;

  int n_cmp = 0;
  int n_err = 0;

`ifdef RF_ARB_STATS_EN
  localparam logic [15:0] EXP_STALLS = 16'd1;
`else
  localparam logic [15:0] EXP_STALLS = 16'd0;
`endif

  rf_write_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4), .STAT_W(16)) dut (
    .clk(clk), .reset(reset),
    .wb_RegWrite(wb_RegWrite), .wb_Write_register(wb_Write_register),
    .wb_Write_data(wb_Write_data),
    .md_valid(md_valid), .md_ready(md_ready),
    .md_Write_register(md_Write_register), .md_Write_data(md_Write_data),
    .RegWrite(RegWrite), .Write_register(Write_register), .Write_data(Write_data),
    .pipe_stall(pipe_stall), .pending_mask(pending_mask), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_set(input logic en, input logic [4:0] r, input logic [31:0] d);
    wb_RegWrite = en; wb_Write_register = r; wb_Write_data = d;
  endtask

  task automatic md_set(input logic en, input logic [4:0] r, input logic [31:0] d);
    md_valid = en; md_Write_register = r; md_Write_data = d;
  endtask

  task automatic test_reset();
    md_set(1'b1, 5'd4, 32'h1); wb_set(1'b1, 5'd4, 32'h1);
    tick();
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL rst_regwrite: got %b want 0", RegWrite); end
    n_cmp++; if (Write_register !== 5'd0) begin n_err++; $display("FAIL rst_wreg: got %0d want 0", Write_register); end
    n_cmp++; if (Write_data !== 32'd0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", Write_data); end
    n_cmp++; if (md_ready !== 1'b0) begin n_err++; $display("FAIL rst_md_ready: got %b want 0", md_ready); end
    n_cmp++; if (pending_mask !== 32'd0) begin n_err++; $display("FAIL rst_mask: got %h want 0", pending_mask); end
    n_cmp++; if (pipe_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", pipe_stall); end
    n_cmp++; if (stall_count !== 16'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", stall_count); end
    md_set(1'b0, 5'd0, 32'd0); wb_set(1'b0, 5'd0, 32'd0);
    reset = 1'b1;
    #1;
    n_cmp++; if (md_ready !== 1'b1) begin n_err++; $display("FAIL idle_md_ready: got %b want 1", md_ready); end
    tick();
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL idle_regwrite: got %b want 0", RegWrite); end
    n_cmp++; if (pending_mask !== 32'd0) begin n_err++; $display("FAIL idle_mask: got %h want 0", pending_mask); end
  endtask

  task automatic test_md_push();
    md_set(1'b1, 5'd8, 32'h42);
    tick();
    md_set(1'b0, 5'd0, 32'd0);
    n_cmp++; if (pending_mask !== 32'h0000_0100) begin n_err++; $display("FAIL md_mask_set: got %h want 00000100", pending_mask); end
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL md_early: got %b want 0", RegWrite); end
    tick();
    n_cmp++; if (RegWrite !== 1'b1) begin n_err++; $display("FAIL md_we: got %b want 1", RegWrite); end
    n_cmp++; if (Write_register !== 5'd8) begin n_err++; $display("FAIL md_wreg: got %0d want 8", Write_register); end
    n_cmp++; if (Write_data !== 32'h42) begin n_err++; $display("FAIL md_wdata: got %h want 42", Write_data); end
    n_cmp++; if (pending_mask !== 32'd0) begin n_err++; $display("FAIL md_mask_clr: got %h want 0", pending_mask); end
    tick();
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL md_after: got %b want 0", RegWrite); end
  endtask

  task automatic test_back_to_back();
    wb_set(1'b1, 5'd1, 32'h100);
    tick();
    n_cmp++; if ({RegWrite, Write_register, Write_data} !== {1'b1, 5'd1, 32'h100}) begin n_err++; $display("FAIL b2b_first: got %b/%0d/%h want 1/1/100", RegWrite, Write_register, Write_data); end
    wb_set(1'b1, 5'd2, 32'h200);
    tick();
    n_cmp++; if ({RegWrite, Write_register, Write_data} !== {1'b1, 5'd2, 32'h200}) begin n_err++; $display("FAIL b2b_second: got %b/%0d/%h want 1/2/200", RegWrite, Write_register, Write_data); end
    wb_set(1'b0, 5'd0, 32'd0);
    tick();
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got %b want 0", RegWrite); end
  endtask

  task automatic test_starve();
    wb_set(1'b1, 5'd9, 32'h99);
    md_set(1'b1, 5'd10, 32'h5);
    tick();
    md_set(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (pipe_stall !== 1'b0) begin n_err++; $display("FAIL starve_early_stall%0d: got %b want 0", i, pipe_stall); end
      n_cmp++; if (Write_register !== 5'd9) begin n_err++; $display("FAIL starve_wb%0d: got %0d want 9", i, Write_register); end
      tick();
    end
    n_cmp++; if (pipe_stall !== 1'b1) begin n_err++; $display("FAIL starve_stall: got %b want 1", pipe_stall); end
    n_cmp++; if (pending_mask !== 32'h0000_0400) begin n_err++; $display("FAIL starve_mask: got %h want 00000400", pending_mask); end
    tick();
    n_cmp++; if (pipe_stall !== 1'b0) begin n_err++; $display("FAIL starve_one_cycle: got %b want 0", pipe_stall); end
    n_cmp++; if ({RegWrite, Write_register, Write_data} !== {1'b1, 5'd10, 32'h5}) begin n_err++; $display("FAIL starve_md_write: got %b/%0d/%h want 1/10/5", RegWrite, Write_register, Write_data); end
    n_cmp++; if (pending_mask !== 32'd0) begin n_err++; $display("FAIL starve_mask_clr: got %h want 0", pending_mask); end
    tick();
    n_cmp++; if ({RegWrite, Write_register, Write_data} !== {1'b1, 5'd9, 32'h99}) begin n_err++; $display("FAIL starve_wb_replay: got %b/%0d/%h want 1/9/99", RegWrite, Write_register, Write_data); end
    n_cmp++; if (stall_count !== EXP_STALLS) begin n_err++; $display("FAIL stall_count: got %0d want %0d", stall_count, EXP_STALLS); end
    wb_set(1'b0, 5'd0, 32'd0);
    tick();
  endtask

  task automatic test_squash();
    wb_set(1'b1, 5'd1, 32'h11);
    md_set(1'b1, 5'd3, 32'hAAAA);
    tick();
    md_set(1'b0, 5'd0, 32'd0);
    n_cmp++; if (pending_mask !== 32'h0000_0008) begin n_err++; $display("FAIL squash_mask_set: got %h want 00000008", pending_mask); end
    wb_set(1'b1, 5'd3, 32'h1234);
    tick();
    n_cmp++; if ({RegWrite, Write_register, Write_data} !== {1'b1, 5'd3, 32'h1234}) begin n_err++; $display("FAIL squash_wb: got %b/%0d/%h want 1/3/1234", RegWrite, Write_register, Write_data); end
    n_cmp++; if (pending_mask !== 32'd0) begin n_err++; $display("FAIL squash_mask_clr: got %h want 0", pending_mask); end
    wb_set(1'b0, 5'd0, 32'd0);
    tick();
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL squash_drop: got %b want 0", RegWrite); end
    n_cmp++; if (md_ready !== 1'b1) begin n_err++; $display("FAIL squash_ready: got %b want 1", md_ready); end
    tick();
  endtask

  task automatic test_full();
    wb_set(1'b1, 5'd5, 32'h55);
    md_set(1'b1, 5'd11, 32'hB1);
    tick();
    md_set(1'b1, 5'd12, 32'hB2);
    tick();
    n_cmp++; if (md_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", md_ready); end
    md_set(1'b1, 5'd13, 32'hB3);
    tick();
    n_cmp++; if (md_ready !== 1'b0) begin n_err++; $display("FAIL full_hold: got %b want 0", md_ready); end
    n_cmp++; if (pending_mask !== 32'h0000_1800) begin n_err++; $display("FAIL full_mask: got %h want 00001800", pending_mask); end
    wb_set(1'b0, 5'd0, 32'd0);
    tick();
    n_cmp++; if (md_ready !== 1'b1) begin n_err++; $display("FAIL full_reopen: got %b want 1", md_ready); end
    n_cmp++; if ({RegWrite, Write_register, Write_data} !== {1'b1, 5'd11, 32'hB1}) begin n_err++; $display("FAIL full_pop1: got %b/%0d/%h want 1/11/B1", RegWrite, Write_register, Write_data); end
    tick();
    md_set(1'b0, 5'd0, 32'd0);
    n_cmp++; if ({RegWrite, Write_register, Write_data} !== {1'b1, 5'd12, 32'hB2}) begin n_err++; $display("FAIL full_pop2: got %b/%0d/%h want 1/12/B2", RegWrite, Write_register, Write_data); end
    n_cmp++; if (pending_mask !== 32'h0000_2000) begin n_err++; $display("FAIL full_mask3: got %h want 00002000", pending_mask); end
    tick();
    n_cmp++; if ({RegWrite, Write_register, Write_data} !== {1'b1, 5'd13, 32'hB3}) begin n_err++; $display("FAIL full_pop3: got %b/%0d/%h want 1/13/B3", RegWrite, Write_register, Write_data); end
    n_cmp++; if (pending_mask !== 32'd0) begin n_err++; $display("FAIL full_mask_clr: got %h want 0", pending_mask); end
    tick();
  endtask

  task automatic test_reg0();
    wb_set(1'b1, 5'd0, 32'hDEAD);
    md_set(1'b1, 5'd0, 32'h77);
    tick();
    md_set(1'b0, 5'd0, 32'd0);
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL r0_wb: got %b want 0", RegWrite); end
    n_cmp++; if (pending_mask !== 32'd0) begin n_err++; $display("FAIL r0_mask: got %h want 0", pending_mask); end
    tick();
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL r0_md: got %b want 0", RegWrite); end
    wb_set(1'b0, 5'd0, 32'd0);
    md_set(1'b1, 5'd6, 32'h66);
    tick();
    md_set(1'b0, 5'd0, 32'd0);
    tick();
    n_cmp++; if ({RegWrite, Write_register, Write_data} !== {1'b1, 5'd6, 32'h66}) begin n_err++; $display("FAIL r0_drain: got %b/%0d/%h want 1/6/66", RegWrite, Write_register, Write_data); end
    tick();
  endtask

  task automatic test_mid_reset();
    wb_set(1'b1, 5'd9, 32'h99);
    md_set(1'b1, 5'd14, 32'hEE);
    tick();
    md_set(1'b0, 5'd0, 32'd0);
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL mid_rst_we: got %b want 0", RegWrite); end
    n_cmp++; if (pending_mask !== 32'd0) begin n_err++; $display("FAIL mid_rst_mask: got %h want 0", pending_mask); end
    n_cmp++; if (md_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready: got %b want 0", md_ready); end
    wb_set(1'b0, 5'd0, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL mid_rst_discard1: got %b want 0", RegWrite); end
    tick();
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL mid_rst_discard2: got %b want 0", RegWrite); end
    n_cmp++; if (stall_count !== 16'd0) begin n_err++; $display("FAIL mid_rst_count: got %0d want 0", stall_count); end
  endtask

  initial begin
    reset = 1'b0;
    wb_set(1'b0, 5'd0, 32'd0);
    md_set(1'b0, 5'd0, 32'd0);
    test_reset();
    test_md_push();
    test_back_to_back();
    test_starve();
    test_squash();
    test_full();
    test_reg0();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
